// File: rtl/ibex_pkg.sv
// Shared FPU operator encoding, bf16 constants and divider state type.
package ibex_pkg;

  typedef enum logic [1:0] {
    FP_ALU_ADD,
    FP_ALU_SUB,
    FP_ALU_MUL,
    FP_ALU_DIV
  } fp_alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    ROUND,
    DONE
  } fp_div_state_e;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [14:0] BF16_INF  = 15'h7F80;
  localparam logic [7:0]  BF16_BIAS = 8'd127;

endpackage

// File: rtl/FP_Class.sv
// bf16 operand classifier (magnitude bits only); subnormals report as zero.
module FP_Class (
  input  logic [14:0] op_i,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);

  logic exp_zero;
  logic exp_max;
  logic man_zero;

  assign exp_zero  = (op_i[14:7] == 8'h00);
  assign exp_max   = (op_i[14:7] == 8'hFF);
  assign man_zero  = (op_i[6:0] == 7'h00);

  assign is_zero_o = exp_zero;
  assign is_inf_o  = exp_max & man_zero;
  assign is_nan_o  = exp_max & ~man_zero;

endmodule

// File: rtl/fp_div_step.sv
// One restoring division step: compare, conditionally subtract, shift left.
module fp_div_step (
  input  logic [8:0] rem_i,
  input  logic [7:0] sb_i,
  output logic [8:0] rem_o,
  output logic       q_o
);

  logic [8:0] diff;

  always_comb begin
    q_o   = (rem_i >= {1'b0, sb_i});
    diff  = q_o ? (rem_i - {1'b0, sb_i}) : rem_i;
    rem_o = diff << 1;
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative bf16 divider C = A / B with RNE rounding, valid/ready handshake and kill.
module fp_div_iter
  import ibex_pkg::*;
#(
  parameter int unsigned RADIX_LOG2 = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  fp_alu_op_e  operator_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] A_i,
  input  logic [15:0] B_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] C_o,
  output logic        dz_o
);

  localparam int unsigned QW       = 10;
  localparam int unsigned ITERS    = QW / RADIX_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(ITERS - 1);

  fp_div_state_e      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [8:0]         rem_q, rem_d;
  logic [QW-1:0]      q_q, q_d;
  logic [7:0]         sb_q, sb_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [15:0]        c_q, c_d;
  logic               dz_q, dz_d;
  logic               ready_q, valid_q;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  FP_Class u_class_a (.op_i(A_i[14:0]), .is_zero_o(a_zero), .is_inf_o(a_inf), .is_nan_o(a_nan));
  FP_Class u_class_b (.op_i(B_i[14:0]), .is_zero_o(b_zero), .is_inf_o(b_inf), .is_nan_o(b_nan));

  // RADIX_LOG2 restoring steps chained per cycle; earlier step yields the more significant bit.
  logic [RADIX_LOG2:0][8:0]  rem_chain;
  logic [RADIX_LOG2-1:0]     qbits;

  assign rem_chain[0] = rem_q;

  for (genvar k = 0; k < RADIX_LOG2; k++) begin : g_step
    fp_div_step u_step (
      .rem_i (rem_chain[k]),
      .sb_i  (sb_q),
      .rem_o (rem_chain[k+1]),
      .q_o   (qbits[RADIX_LOG2-1-k])
    );
  end

  // Special-case detection on the live operands, first match wins.
  logic        in_sign;
  logic        spec_hit;
  logic        spec_dz;
  logic [15:0] spec_res;

  always_comb begin
    in_sign  = A_i[15] ^ B_i[15];
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_res = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = BF16_QNAN;
    end else if (a_inf) begin
      spec_res = {in_sign, BF16_INF};
    end else if (b_zero) begin
      spec_res = {in_sign, BF16_INF};
      spec_dz  = 1'b1;
    end else if (b_inf || a_zero) begin
      spec_res = {in_sign, 15'h0000};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalise the quotient, round to nearest even, then range-check the exponent.
  logic [6:0]        mant;
  logic              guard;
  logic              sticky;
  logic [7:0]        mant_r;
  logic signed [9:0] e_adj;
  logic signed [9:0] e_fin;
  logic [15:0]       round_res;

  always_comb begin
    if (q_q[9]) begin
      mant   = q_q[8:2];
      guard  = q_q[1];
      sticky = q_q[0] | (rem_q != 9'd0);
      e_adj  = exp_q;
    end else begin
      mant   = q_q[7:1];
      guard  = q_q[0];
      sticky = (rem_q != 9'd0);
      e_adj  = exp_q - 10'sd1;
    end
    mant_r = {1'b0, mant} + 8'(guard & (sticky | mant[0]));
    e_fin  = mant_r[7] ? (e_adj + 10'sd1) : e_adj;
    if (e_fin >= 10'sd255) begin
      round_res = {sign_q, BF16_INF};
    end else if (e_fin <= 10'sd0) begin
      round_res = {sign_q, 15'h0000};
    end else begin
      round_res = {sign_q, e_fin[7:0], mant_r[6:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    sb_d    = sb_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    c_d     = c_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (valid_i && (operator_i == FP_ALU_DIV)) begin
          sign_d = in_sign;
          exp_d  = 10'({2'b00, A_i[14:7]}) - 10'({2'b00, B_i[14:7]}) + 10'({2'b00, BF16_BIAS});
          sb_d   = {1'b1, B_i[6:0]};
          rem_d  = {2'b01, A_i[6:0]};
          q_d    = '0;
          cnt_d  = CNT_INIT;
          if (spec_hit) begin
            c_d     = spec_res;
            dz_d    = spec_dz;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d = rem_chain[RADIX_LOG2];
        q_d   = {q_q[QW-1-RADIX_LOG2:0], qbits};
        if (cnt_q == 4'd0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ROUND: begin
        c_d     = round_res;
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      sb_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      c_q     <= 16'h0000;
      dz_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      sb_q    <= sb_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign C_o     = c_q;
  assign dz_o    = dz_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: radix-2 and radix-4 instances driven in lockstep against an arithmetic model.
module tb_fp_div_iter;

  logic                 clk;
  logic                 rst_n;
  ibex_pkg::fp_alu_op_e op;
  logic                 vin;
  logic [15:0]          a_in;
  logic [15:0]          b_in;
  logic                 kill;
  logic                 rdy_in;

  logic        rdy1, vout1, dz1;
  logic [15:0] c1;
  logic        rdy2, vout2, dz2;
  logic [15:0] c2;

  int total = 0;
  int bad   = 0;

  fp_div_iter #(.RADIX_LOG2(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .operator_i(op), .valid_i(vin), .ready_o(rdy1),
    .A_i(a_in), .B_i(b_in), .kill_i(kill), .valid_o(vout1), .ready_i(rdy_in),
    .C_o(c1), .dz_o(dz1)
  );

  fp_div_iter #(.RADIX_LOG2(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .operator_i(op), .valid_i(vin), .ready_o(rdy2),
    .A_i(a_in), .B_i(b_in), .kill_i(kill), .valid_o(vout2), .ready_i(rdy_in),
    .C_o(c2), .dz_o(dz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classify, then integer long division of the scaled significands.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] c, output logic dz, output int lat1,
                                  output int lat2);
    logic s;
    int   ea, eb, e, q, r, m, ma, mb;
    bit   az, bz, ai, bi, an, bn, g, st;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[6:0] == 7'd0);
    bi = (eb == 255) && (b[6:0] == 7'd0);
    an = (ea == 255) && (a[6:0] != 7'd0);
    bn = (eb == 255) && (b[6:0] != 7'd0);
    dz   = 1'b0;
    lat1 = 1;
    lat2 = 1;
    if (an || bn || (ai && bi) || (az && bz)) c = 16'h7FC0;
    else if (ai) c = {s, 15'h7F80};
    else if (bz) begin
      c  = {s, 15'h7F80};
      dz = 1'b1;
    end else if (bi || az) c = {s, 15'h0000};
    else begin
      lat1 = 12;
      lat2 = 7;
      q = (ma * 512) / mb;
      r = (ma * 512) % mb;
      e = ea - eb + 127;
      if (q >= 512) begin
        m  = (q >> 2) & 127;
        g  = ((q >> 1) & 1) != 0;
        st = ((q & 1) != 0) || (r != 0);
      end else begin
        e  = e - 1;
        m  = (q >> 1) & 127;
        g  = (q & 1) != 0;
        st = (r != 0);
      end
      if (g && (st || ((m & 1) != 0))) m = m + 1;
      if (m == 128) begin
        m = 0;
        e = e + 1;
      end
      if (e >= 255) c = {s, 15'h7F80};
      else if (e <= 0) c = {s, 15'h0000};
      else c = {s, 8'(e), 7'(m)};
    end
  endfunction

  function automatic logic [15:0] rand_bf16();
    int         k;
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
    k = int'($urandom_range(0, 11));
    s = 1'($urandom);
    m = 7'($urandom);
    case (k)
      0:       e = 8'h00;
      1: begin e = 8'hFF; m = 7'h00; end
      2: begin e = 8'hFF; m = m | 7'h01; end
      3, 4, 5: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(110, 144));
    endcase
    return {s, e, m};
  endfunction

  // Issue one divide with ready_i=1 and collect each instance's first result and its latency.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] oc1, output logic odz1, output int ol1,
                         output logic [15:0] oc2, output logic odz2, output int ol2);
    @(negedge clk);
    op     = ibex_pkg::FP_ALU_DIV;
    a_in   = a;
    b_in   = b;
    vin    = 1'b1;
    rdy_in = 1'b1;
    ol1 = -1; ol2 = -1; oc1 = 'x; oc2 = 'x; odz1 = 'x; odz2 = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      vin = 1'b0;
      if (vout1 && ol1 < 0) begin ol1 = n; oc1 = c1; odz1 = dz1; end
      if (vout2 && ol2 < 0) begin ol2 = n; oc2 = c2; odz2 = dz2; end
      if (ol1 > 0 && ol2 > 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({rdy1, vout1, c1, dz1, rdy2, vout2, c2, dz2} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset: r1=%b v1=%b c1=%h dz1=%b r2=%b v2=%b c2=%h dz2=%b want 1/0/0000/0", rdy1, vout1, c1, dz1, rdy2, vout2, c2, dz2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rdy1, vout1, rdy2, vout2} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_release: r1=%b v1=%b r2=%b v2=%b want 1 0 1 0", rdy1, vout1, rdy2, vout2);
    end
  endtask

  // Directed vector: expected value and latency come from the caller's constants.
  task automatic test_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ec, input logic edz, input int el1, input int el2);
    logic [15:0] rc1, rc2;
    logic        rd1, rd2;
    int          l1, l2;
    run_div(a, b, rc1, rd1, l1, rc2, rd2, l2);
    total++;
    if (rc1 !== ec || rd1 !== edz || l1 != el1) begin
      bad++;
      $display("FAIL %s r1: got c=%h dz=%b lat=%0d want c=%h dz=%b lat=%0d", name, rc1, rd1, l1, ec, edz, el1);
    end
    total++;
    if (rc2 !== ec || rd2 !== edz || l2 != el2) begin
      bad++;
      $display("FAIL %s r2: got c=%h dz=%b lat=%0d want c=%h dz=%b lat=%0d", name, rc2, rd2, l2, ec, edz, el2);
    end
  endtask

  task automatic test_random(input int n_ops);
    logic [15:0] a, b, ec, rc1, rc2;
    logic        edz, rd1, rd2;
    int          el1, el2, l1, l2;
    for (int i = 0; i < n_ops; i++) begin
      a = rand_bf16();
      b = rand_bf16();
      ref_div(a, b, ec, edz, el1, el2);
      run_div(a, b, rc1, rd1, l1, rc2, rd2, l2);
      total++;
      if (rc1 !== ec || rd1 !== edz || l1 != el1) begin
        bad++;
        $display("FAIL random r1 %h/%h: got c=%h dz=%b lat=%0d want c=%h dz=%b lat=%0d", a, b, rc1, rd1, l1, ec, edz, el1);
      end
      total++;
      if (rc2 !== ec || rd2 !== edz || l2 != el2) begin
        bad++;
        $display("FAIL random r2 %h/%h: got c=%h dz=%b lat=%0d want c=%h dz=%b lat=%0d", a, b, rc2, rd2, l2, ec, edz, el2);
      end
    end
  endtask

  task automatic test_ignore_op();
    bit seen;
    seen = 0;
    @(negedge clk);
    op   = ibex_pkg::FP_ALU_MUL;
    a_in = 16'h40C0;
    b_in = 16'h4000;
    vin  = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (vout1 || vout2 || !rdy1 || !rdy2) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL ignore_op: non-divide op started a divide, got activity=1 want 0");
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] ec;
    logic        edz, held_ok;
    int          el1, el2, waited;
    ref_div(16'h3F80, 16'h4040, ec, edz, el1, el2);
    @(negedge clk);
    op = ibex_pkg::FP_ALU_DIV; a_in = 16'h3F80; b_in = 16'h4040;
    vin = 1'b1; rdy_in = 1'b0;
    @(negedge clk);
    vin = 1'b0;
    waited = 0;
    while (!(vout1 && vout2) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!(vout1 && vout2)) begin
      bad++;
      $display("FAIL bp_arrive: v1=%b v2=%b want 1 1", vout1, vout2);
    end
    held_ok = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!(vout1 && vout2 && c1 === ec && c2 === ec && !rdy1 && !rdy2)) held_ok = 1'b0;
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL bp_hold: v1=%b v2=%b c1=%h c2=%h r1=%b r2=%b want v=1 c=%h r=0", vout1, vout2, c1, c2, rdy1, rdy2, ec);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    total++;
    if ({vout1, vout2, rdy1, rdy2} !== 4'b0011) begin
      bad++;
      $display("FAIL bp_consume: v1=%b v2=%b r1=%b r2=%b want 0 0 1 1", vout1, vout2, rdy1, rdy2);
    end
  endtask

  task automatic test_kill();
    bit seen;
    @(negedge clk);
    op = ibex_pkg::FP_ALU_DIV; a_in = 16'h40C0; b_in = 16'h4000;
    vin = 1'b1; rdy_in = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      vin = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    total++;
    if ({rdy1, rdy2, vout1, vout2} !== 4'b1100) begin
      bad++;
      $display("FAIL kill_idle: r1=%b r2=%b v1=%b v2=%b want 1 1 0 0", rdy1, rdy2, vout1, vout2);
    end
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (vout1 || vout2) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL kill_noresult: valid seen=1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = ibex_pkg::FP_ALU_DIV; a_in = 16'h3F80; b_in = 16'h4040;
    vin = 1'b1; rdy_in = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      vin = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdy1, vout1, c1, dz1, rdy2, vout2, c2, dz2} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid: r1=%b v1=%b c1=%h dz1=%b r2=%b v2=%b c2=%h dz2=%b want 1/0/0000/0", rdy1, vout1, c1, dz1, rdy2, vout2, c2, dz2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vec("after_reset_1_1", 16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 12, 7);
  endtask

  initial begin
    op = ibex_pkg::FP_ALU_DIV; vin = 1'b0; a_in = '0; b_in = '0; kill = 1'b0; rdy_in = 1'b1;
    test_reset();
    test_vec("div_6_2",      16'h40C0, 16'h4000, 16'h4040, 1'b0, 12, 7);
    test_vec("div_1_3",      16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 12, 7);
    test_vec("div_m1_3",     16'hBF80, 16'h4040, 16'hBEAB, 1'b0, 12, 7);
    test_vec("neg_by_zero",  16'hBF80, 16'h0000, 16'hFF80, 1'b1, 1, 1);
    test_vec("zero_by_zero", 16'h0000, 16'h8000, 16'h7FC0, 1'b0, 1, 1);
    test_vec("inf_by_inf",   16'h7F80, 16'h7F80, 16'h7FC0, 1'b0, 1, 1);
    test_vec("fin_by_ninf",  16'h3F80, 16'hFF80, 16'h8000, 1'b0, 1, 1);
    test_vec("overflow",     16'h7F7F, 16'h3F00, 16'h7F80, 1'b0, 12, 7);
    test_vec("underflow",    16'h0080, 16'h4000, 16'h0000, 1'b0, 12, 7);
    test_ignore_op();
    test_random(60);
    test_back_pressure();
    test_kill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
